// File: rtl/game_timer.sv
// Game countdown timer with BCD minute/second digits, one-second prescaler and low-time warning.
// Optional star bonus (+10 s, saturating at 9:59) is enabled by defining GAME_TIMER_BONUS_EN.
module game_timer #(
  parameter int unsigned CLK_HZ      = 100000000,
  parameter int unsigned START_MIN   = 4,
  parameter int unsigned START_SEC_T = 4,
  parameter int unsigned START_SEC_U = 4,
  parameter int unsigned WARN_SEC    = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] state,
  input  logic       bonus_pulse,
  output logic [3:0] time_min,
  output logic [3:0] time_sec_t,
  output logic [3:0] time_sec_u,
  output logic       sec_pulse,
  output logic       expired,
  output logic       warn
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(CLK_HZ - 1);

  localparam logic [3:0] StartMin  = 4'(START_MIN);
  localparam logic [3:0] StartSecT = 4'(START_SEC_T);
  localparam logic [3:0] StartSecU = 4'(START_SEC_U);

  localparam logic [2:0] StGame = 3'd2;
  localparam logic [2:0] StWin  = 3'd3;
  localparam logic [2:0] StLose = 3'd4;

  if (START_MIN > 9 || START_SEC_T > 5 || START_SEC_U > 9 ||
      (START_MIN == 0 && START_SEC_T == 0 && START_SEC_U == 0) || CLK_HZ < 2) begin : g_bad_param
    $error("game_timer: illegal start time or CLK_HZ");
  end

  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    min_q, min_d;
  logic [3:0]    sec_t_q, sec_t_d;
  logic [3:0]    sec_u_q, sec_u_d;
  logic          sec_pulse_q, sec_pulse_d;
  logic          expired_q, expired_d;

  logic          time_zero;
  logic          dec_now;
  logic [3:0]    dm, dt, du;
  logic [9:0]    total_sec;

  assign time_zero = (min_q == 4'd0) && (sec_t_q == 4'd0) && (sec_u_q == 4'd0);
  assign dec_now   = (presc_q == PrescMax);

`ifndef GAME_TIMER_BONUS_EN
  logic unused_bonus;
  assign unused_bonus = bonus_pulse;
`endif

  always_comb begin
    presc_d     = presc_q;
    min_d       = min_q;
    sec_t_d     = sec_t_q;
    sec_u_d     = sec_u_q;
    sec_pulse_d = 1'b0;
    expired_d   = expired_q;
    dm          = min_q;
    dt          = sec_t_q;
    du          = sec_u_q;

    unique case (state)
      StGame: begin
        // At 0:00 (or once expired) everything freezes, prescaler included.
        if (!expired_q && !time_zero) begin
          if (dec_now) begin
            presc_d     = '0;
            sec_pulse_d = 1'b1;
            if (du != 4'd0) begin
              du = du - 4'd1;
            end else begin
              du = 4'd9;
              if (dt != 4'd0) begin
                dt = dt - 4'd1;
              end else begin
                dt = 4'd5;
                dm = dm - 4'd1;
              end
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
`ifdef GAME_TIMER_BONUS_EN
          // Bonus is applied on top of any same-edge decrement (net +9 s).
          if (bonus_pulse) begin
            if (dt == 4'd5) begin
              if (dm == 4'd9) begin
                du = 4'd9;
              end else begin
                dt = 4'd0;
                dm = dm + 4'd1;
              end
            end else begin
              dt = dt + 4'd1;
            end
          end
`endif
          min_d     = dm;
          sec_t_d   = dt;
          sec_u_d   = du;
          expired_d = (dm == 4'd0) && (dt == 4'd0) && (du == 4'd0);
        end
      end
      StWin, StLose: begin
      end
      default: begin
        presc_d   = '0;
        min_d     = StartMin;
        sec_t_d   = StartSecT;
        sec_u_d   = StartSecU;
        expired_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q     <= '0;
      min_q       <= StartMin;
      sec_t_q     <= StartSecT;
      sec_u_q     <= StartSecU;
      sec_pulse_q <= 1'b0;
      expired_q   <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      min_q       <= min_d;
      sec_t_q     <= sec_t_d;
      sec_u_q     <= sec_u_d;
      sec_pulse_q <= sec_pulse_d;
      expired_q   <= expired_d;
    end
  end

  assign total_sec = 10'(min_q) * 10'd60 + 10'(sec_t_q) * 10'd10 + 10'(sec_u_q);

  always_comb begin
    warn = ({22'd0, total_sec} <= WARN_SEC) && (state == StGame) && !expired_q;
  end

  assign time_min   = min_q;
  assign time_sec_t = sec_t_q;
  assign time_sec_u = sec_u_q;
  assign sec_pulse  = sec_pulse_q;
  assign expired    = expired_q;

endmodule

// File: tb/tb_game_timer.sv
// Randomized bench for game_timer: three instances (start 4:44, 0:01, 1:00) checked every cycle
// against a remaining-seconds model, plus hand-computed checkpoints.
module tb_game_timer;

  localparam int ClkHz = 4;
  localparam int Warn  = 30;
`ifdef GAME_TIMER_BONUS_EN
  localparam bit BonusEn = 1'b1;
`else
  localparam bit BonusEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] state = 3'd0;
  logic       bonus = 1'b0;

  logic [3:0] o_min [3];
  logic [3:0] o_t   [3];
  logic [3:0] o_u   [3];
  logic       o_pul [3];
  logic       o_exp [3];
  logic       o_wrn [3];

  always #5 clk = ~clk;

  game_timer #(.CLK_HZ(ClkHz), .START_MIN(4), .START_SEC_T(4), .START_SEC_U(4),
               .WARN_SEC(Warn)) dut_a (
    .clk(clk), .rst(rst), .state(state), .bonus_pulse(bonus),
    .time_min(o_min[0]), .time_sec_t(o_t[0]), .time_sec_u(o_u[0]),
    .sec_pulse(o_pul[0]), .expired(o_exp[0]), .warn(o_wrn[0]));

  game_timer #(.CLK_HZ(ClkHz), .START_MIN(0), .START_SEC_T(0), .START_SEC_U(1),
               .WARN_SEC(Warn)) dut_b (
    .clk(clk), .rst(rst), .state(state), .bonus_pulse(bonus),
    .time_min(o_min[1]), .time_sec_t(o_t[1]), .time_sec_u(o_u[1]),
    .sec_pulse(o_pul[1]), .expired(o_exp[1]), .warn(o_wrn[1]));

  game_timer #(.CLK_HZ(ClkHz), .START_MIN(1), .START_SEC_T(0), .START_SEC_U(0),
               .WARN_SEC(Warn)) dut_c (
    .clk(clk), .rst(rst), .state(state), .bonus_pulse(bonus),
    .time_min(o_min[2]), .time_sec_t(o_t[2]), .time_sec_u(o_u[2]),
    .sec_pulse(o_pul[2]), .expired(o_exp[2]), .warn(o_wrn[2]));

  // Model tracks remaining time as a plain count of seconds.
  typedef struct packed {
    int   rem;
    int   presc;
    logic exp;
    logic pulse;
  } mstate_t;

  mstate_t m [3];
  int  n_checks = 0;
  int  n_fail   = 0;
  bit  chk_en   = 1'b0;

  function automatic int start_of(input int i);
    case (i)
      0:       return 284;
      1:       return 1;
      default: return 60;
    endcase
  endfunction

  function automatic mstate_t reset_of(input int i);
    mstate_t r;
    r.rem = start_of(i);
    r.presc = 0;
    r.exp = 1'b0;
    r.pulse = 1'b0;
    return r;
  endfunction

  function automatic mstate_t nxt(input mstate_t c, input int i, input logic [2:0] s,
                                  input logic b);
    mstate_t n;
    bit dec;
    n = c;
    n.pulse = 1'b0;
    if (s == 3'd0 || s == 3'd1 || s > 3'd4) begin
      n = reset_of(i);
    end else if (s == 3'd2 && !c.exp && c.rem != 0) begin
      dec = (c.presc == ClkHz - 1);
      n.presc = dec ? 0 : c.presc + 1;
      n.rem = c.rem - (dec ? 1 : 0);
      if (BonusEn && b) n.rem = (n.rem + 10 > 599) ? 599 : n.rem + 10;
      n.pulse = dec;
      n.exp = (n.rem == 0);
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) m[i] <= reset_of(i);
    end else begin
      for (int i = 0; i < 3; i++) m[i] <= nxt(m[i], i, state, bonus);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("min[%0d]", i), 32'(o_min[i]), m[i].rem / 60);
        chk($sformatf("sec_t[%0d]", i), 32'(o_t[i]), (m[i].rem % 60) / 10);
        chk($sformatf("sec_u[%0d]", i), 32'(o_u[i]), m[i].rem % 10);
        chk($sformatf("sec_pulse[%0d]", i), 32'(o_pul[i]), 32'(m[i].pulse));
        chk($sformatf("expired[%0d]", i), 32'(o_exp[i]), 32'(m[i].exp));
        chk($sformatf("warn[%0d]", i), 32'(o_wrn[i]),
            32'(state == 3'd2 && !m[i].exp && m[i].rem <= Warn));
      end
    end
  end

  // Drive inputs just after a falling edge, return 1 time unit after the next falling edge.
  task automatic tick(input logic [2:0] s, input logic b);
    state = s;
    bonus = b;
    @(negedge clk);
    #1;
  endtask

  task automatic chk_time(input string nm, input int i, input int mn, input int t, input int u);
    chk({nm, ".min"}, 32'(o_min[i]), mn);
    chk({nm, ".t"}, 32'(o_t[i]), t);
    chk({nm, ".u"}, 32'(o_u[i]), u);
  endtask

  initial begin
    int pulses;
    int run;
    int rst_hold;
    int r;
    logic [2:0] cur;

    tick(3'd0, 1'b0);
    tick(3'd2, 1'b0);
    chk_en = 1'b1;
    chk_time("reset_a", 0, 4, 4, 4);
    chk("reset_pulse", 32'(o_pul[0]), 0);
    chk("reset_exp", 32'(o_exp[0]), 0);

    rst = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 120; k++) begin
      tick(3'd2, 1'b0);
      if (k <= 4 && o_pul[0]) pulses++;
      if (k == 4) begin
        chk("first_sec_pulses", pulses, 1);
        chk_time("first_sec_a", 0, 4, 4, 3);
        chk_time("expire_b", 1, 0, 0, 0);
        chk("expire_b.exp", 32'(o_exp[1]), 1);
        chk_time("one_min_c", 2, 0, 5, 9);
        chk("one_min_c.warn", 32'(o_wrn[2]), 0);
        pulses = 0;
      end
      if (k > 4 && k <= 24 && o_pul[1]) pulses++;
      if (k == 24) begin
        chk("hold_b.pulses", pulses, 0);
        chk_time("hold_b", 1, 0, 0, 0);
      end
      if (k == 116) begin
        chk_time("c_0_31", 2, 0, 3, 1);
        chk("c_0_31.warn", 32'(o_wrn[2]), 0);
      end
    end
    chk_time("c_0_30", 2, 0, 3, 0);
    chk("c_0_30.warn", 32'(o_wrn[2]), 1);

    // Pause mid-second in WIN, resume, then reload through WAIT.
    tick(3'd2, 1'b0);
    tick(3'd2, 1'b0);
    for (int k = 0; k < 10; k++) tick(3'd3, 1'b0);
    chk_time("win_hold", 0, 4, 1, 4);
    chk("win_exp_b", 32'(o_exp[1]), 1);
    tick(3'd2, 1'b0);
    chk("resume1.pulse", 32'(o_pul[0]), 0);
    chk_time("resume1", 0, 4, 1, 4);
    tick(3'd2, 1'b0);
    chk("resume2.pulse", 32'(o_pul[0]), 1);
    chk_time("resume2", 0, 4, 1, 3);
    tick(3'd1, 1'b0);
    chk_time("wait_reload", 0, 4, 4, 4);
    chk("wait_exp_b", 32'(o_exp[1]), 0);

    // Reach 2:50 with prescaler at 3, then bonus on the decrement edge and off it.
    for (int k = 0; k < 459; k++) tick(3'd2, 1'b0);
    chk_time("at_2_50", 0, 2, 5, 0);
    tick(3'd2, 1'b1);
    chk("bonus_dec.pulse", 32'(o_pul[0]), 1);
    if (BonusEn) chk_time("bonus_dec", 0, 2, 5, 9);
    else         chk_time("bonus_dec", 0, 2, 4, 9);
    tick(3'd2, 1'b1);
    if (BonusEn) chk_time("bonus_plain", 0, 3, 0, 9);
    else         chk_time("bonus_plain", 0, 2, 4, 9);

    // Asynchronous reset in the middle of a second.
    tick(3'd2, 1'b0);
    rst = 1'b0;
    #2;
    chk_time("async_rst", 0, 4, 4, 4);
    chk("async_rst.exp_b", 32'(o_exp[1]), 0);
    chk("async_rst.pulse", 32'(o_pul[0]), 0);
    tick(3'd2, 1'b0);
    rst = 1'b1;

    run = 0;
    rst_hold = 0;
    cur = 3'd2;
    for (int k = 0; k < 4000; k++) begin
      if (run == 0) begin
        r = int'($urandom_range(0, 99));
        if (r < 70)      cur = 3'd2;
        else if (r < 80) cur = 3'd3;
        else if (r < 88) cur = 3'd4;
        else if (r < 95) cur = 3'd1;
        else if (r < 97) cur = 3'd0;
        else             cur = 3'($urandom_range(5, 7));
        run = int'($urandom_range(1, 300));
      end
      run--;
      tick(cur, $urandom_range(0, 15) == 0);
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst = 1'b1;
      end else if ($urandom_range(0, 599) == 0) begin
        rst = 1'b0;
        rst_hold = int'($urandom_range(1, 3));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
